program_loader: RTL



---
 rtl/program_loader_pkg.sv | 13 +
 rtl/program_loader.sv | 107 ++++++++++
 2 files changed

// File: rtl/program_loader_pkg.sv
// Processor-wide boot constants shared by the boot ROM program and the hardware boot copier.
package program_loader_pkg;

  localparam int BOOT_DATA_WIDTH    = 32;
  localparam int BOOT_HD_ADDR_WIDTH = 10;
  localparam int BOOT_IM_ADDR_WIDTH = 10;

  // Must match the addresses the boot ROM program copies from and to.
  localparam int BOOT_SRC_BASE  = 0;
  localparam int BOOT_DST_BASE  = 256;
  localparam int BOOT_MAX_WORDS = 256;

endpackage

// File: rtl/program_loader.sv
// Hardware boot copier: reads HD words from SRC_BASE into instruction memory at DST_BASE
// until a non-positive word or MAX_WORDS, then pulses done.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int DATA_WIDTH    = BOOT_DATA_WIDTH,
  parameter int HD_ADDR_WIDTH = BOOT_HD_ADDR_WIDTH,
  parameter int IM_ADDR_WIDTH = BOOT_IM_ADDR_WIDTH,
  parameter int SRC_BASE      = BOOT_SRC_BASE,
  parameter int DST_BASE      = BOOT_DST_BASE,
  parameter int MAX_WORDS     = BOOT_MAX_WORDS
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  output logic                     hd_read,
  output logic [HD_ADDR_WIDTH-1:0] hd_address,
  input  logic [DATA_WIDTH-1:0]    hd_data,
  input  logic                     hd_valid,
  output logic                     im_write,
  output logic [IM_ADDR_WIDTH-1:0] im_address,
  output logic [DATA_WIDTH-1:0]    im_data,
  output logic                     busy,
  output logic                     done,
  output logic [IM_ADDR_WIDTH:0]   word_count
);

  localparam int CW = IM_ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t          state;
  logic [CW-1:0]   next_count;
  logic            terminator;

  assign next_count = word_count + CW'(1);
  // Signed <= 0: sign bit set or all zeros.
  assign terminator = hd_data[DATA_WIDTH-1] | ~|hd_data;

  // NOTE: every output is a register loaded on the transition into the state that
  // asserts it, so strobes line up with the state rather than lagging by a cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      hd_read    <= 1'b0;
      hd_address <= '0;
      im_write   <= 1'b0;
      im_address <= '0;
      im_data    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      word_count <= '0;
    end else begin
      hd_read  <= 1'b0;
      im_write <= 1'b0;
      done     <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_READ;
            word_count <= '0;
            busy       <= 1'b1;
            hd_read    <= 1'b1;
            hd_address <= HD_ADDR_WIDTH'(SRC_BASE);
          end
        end
        S_READ: state <= S_WAIT;
        S_WAIT: begin
          if (hd_valid) begin
            if (terminator) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state      <= S_WRITE;
              im_write   <= 1'b1;
              im_address <= IM_ADDR_WIDTH'(DST_BASE) + IM_ADDR_WIDTH'(word_count);
              im_data    <= hd_data;
            end
          end
        end
        S_WRITE: begin
          word_count <= next_count;
          if (next_count == CW'(MAX_WORDS)) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            state      <= S_READ;
            hd_read    <= 1'b1;
            hd_address <= HD_ADDR_WIDTH'(SRC_BASE) + HD_ADDR_WIDTH'(next_count);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
